// File: rtl/mul_rr_scheduler.sv
// Round-robin front end sharing one pipelined 32x32 multiplier among NREQ requesters.
// Define MUL_SIGNED_EN for two's-complement operands (magnitudes issued, sign restored on return).
module mul_rr_scheduler #(
  parameter int NREQ        = 4,
  parameter int MUL_LATENCY = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_p,
  output logic [NREQ-1:0]      resp_valid,
  output logic [63:0]          resp_p,
  output logic                 busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]         ptr_q, ptr_d;
  logic                   grant_vld;
  logic [IDW-1:0]         grant_id;
  logic [NREQ-1:0]        grant_oh;
  logic [31:0]            sel_a, sel_b;
  logic [31:0]            iss_a, iss_b;
  logic [31:0]            mul_a_q, mul_b_q;
  logic [MUL_LATENCY-1:0] tag_v_q;
  logic [IDW-1:0]         tag_id_q [MUL_LATENCY];
  logic [NREQ-1:0]        resp_valid_q, resp_valid_d;
  logic [63:0]            resp_p_q, resp_p_d;
`ifdef MUL_SIGNED_EN
  logic                   iss_neg;
  logic [MUL_LATENCY-1:0] tag_neg_q;
`endif

  // Search starts just after the last winner, wrapping modulo NREQ.
  always_comb begin
    int unsigned cand;
    logic [IDW-1:0] cand_id;
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned j = 1; j <= NREQ; j++) begin
      cand    = (32'(ptr_q) + j) % NREQ;
      cand_id = IDW'(cand);
      if (!grant_vld && req_valid[cand_id]) begin
        grant_vld = 1'b1;
        grant_id  = cand_id;
      end
    end
    if (!reset_n) grant_vld = 1'b0;
    if (grant_vld) grant_oh[grant_id] = 1'b1;
  end

  assign req_ready = grant_oh;
  assign ptr_d     = grant_vld ? grant_id : ptr_q;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_a = req_a[i*32 +: 32];
        sel_b = req_b[i*32 +: 32];
      end
    end
  end

`ifdef MUL_SIGNED_EN
  // |-2^31| wraps to 0x8000_0000, which is the correct unsigned magnitude.
  assign iss_a   = sel_a[31] ? (~sel_a + 32'd1) : sel_a;
  assign iss_b   = sel_b[31] ? (~sel_b + 32'd1) : sel_b;
  assign iss_neg = sel_a[31] ^ sel_b[31];
  assign resp_p_d = tag_neg_q[MUL_LATENCY-1] ? (~mul_p + 64'd1) : mul_p;
`else
  assign iss_a    = sel_a;
  assign iss_b    = sel_b;
  assign resp_p_d = mul_p;
`endif

  always_comb begin
    resp_valid_d = '0;
    if (tag_v_q[MUL_LATENCY-1]) resp_valid_d[tag_id_q[MUL_LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q        <= IDW'(NREQ - 1);
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_v_q      <= '0;
      resp_valid_q <= '0;
      resp_p_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tag_v_q      <= {tag_v_q[MUL_LATENCY-2:0], grant_vld};
      resp_valid_q <= resp_valid_d;
      if (grant_vld) begin
        mul_a_q <= iss_a;
        mul_b_q <= iss_b;
      end
      if (tag_v_q[MUL_LATENCY-1]) resp_p_q <= resp_p_d;
    end
  end

  // Tag payload needs no reset: it is qualified by tag_v_q.
  always_ff @(posedge clock) begin
    tag_id_q[0] <= grant_id;
    for (int unsigned i = 1; i < MUL_LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
`ifdef MUL_SIGNED_EN
    tag_neg_q <= {tag_neg_q[MUL_LATENCY-2:0], iss_neg};
`endif
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_p     = resp_p_q;
  assign busy       = (|tag_v_q) | (|resp_valid_q);

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: queue-based reference model plus directed literal checks.
module tb_mul_rr_scheduler;

  localparam int NREQ = 4;
  localparam int LAT  = 10;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          mul_a;
  logic [31:0]          mul_b;
  logic [63:0]          mul_p;
  logic [NREQ-1:0]      resp_valid;
  logic [63:0]          resp_p;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  mul_rr_scheduler #(.NREQ(NREQ), .MUL_LATENCY(LAT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .resp_valid (resp_valid),
    .resp_p     (resp_p),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Multiplier: mul_a/mul_b register plus LAT-1 product stages = LAT clocks.
  logic [63:0] mpipe [LAT-1];
  always @(posedge clock) begin
    mpipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int i = 1; i < LAT - 1; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[LAT-2];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [NREQ-1:0] oh(int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  function automatic logic [63:0] model_product(logic [31:0] a, logic [31:0] b);
`ifdef MUL_SIGNED_EN
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  // Reference model: grant by rotating priority, responses queued by due cycle.
  typedef struct {
    int unsigned     due;
    logic [NREQ-1:0] id_oh;
    logic [63:0]     p;
  } rsp_t;

  rsp_t            rq[$];
  int unsigned     m_cyc    = 0;
  int              m_ptr    = NREQ - 1;
  logic [63:0]     m_last_p = '0;

  always @(negedge clock) begin
    logic [NREQ-1:0] exp_rdy, exp_rv;
    logic [63:0]     exp_p;
    int              g;
    int              c;
    rsp_t            e;
    exp_rv = '0;
    exp_p  = m_last_p;
    if (rq.size() != 0 && rq[0].due == m_cyc) begin
      exp_rv = rq[0].id_oh;
      exp_p  = rq[0].p;
    end
    g = -1;
    if (reset_n) begin
      for (int j = 1; j <= NREQ; j++) begin
        c = (m_ptr + j) % NREQ;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? oh(g) : '0;
    chk("ready", 64'(req_ready), 64'(exp_rdy));
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    chk("resp_p", resp_p, exp_p);
    chk("busy", 64'(busy), 64'(rq.size() != 0));
    if (exp_rv != '0) begin
      m_last_p = exp_p;
      void'(rq.pop_front());
    end
    if (!reset_n) begin
      rq.delete();
      m_ptr    = NREQ - 1;
      m_last_p = '0;
    end else if (g >= 0) begin
      e.due   = m_cyc + LAT + 1;
      e.id_oh = oh(g);
      e.p     = model_product(req_a[g*32 +: 32], req_b[g*32 +: 32]);
      rq.push_back(e);
      m_ptr = g;
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(int id, logic [31:0] a, logic [31:0] b);
    req_valid[id]       = 1'b1;
    req_a[id*32 +: 32]  = a;
    req_b[id*32 +: 32]  = b;
  endtask

  function automatic logic [31:0] rop();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue_and_check(string nm, int id, logic [31:0] a, logic [31:0] b,
                                 logic [63:0] exp);
    tick();
    req_valid = '0;
    set_req(id, a, b);
    @(negedge clock);
    chk({nm, "_ready"}, 64'(req_ready), 64'(oh(id)));
    tick();
    req_valid[id] = 1'b0;
    repeat (LAT) @(posedge clock);
    @(negedge clock);
    chk({nm, "_rv"}, 64'(resp_valid), 64'(oh(id)));
    chk({nm, "_p"}, resp_p, exp);
  endtask

`ifdef MUL_SIGNED_EN
  localparam logic [63:0] EXP_SINGLE = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] EXP_M3X7   = 64'hFFFF_FFFF_FFFF_FFEB;
`else
  localparam logic [63:0] EXP_SINGLE = 64'h0000_0001_FFFF_FFFE;
  localparam logic [63:0] EXP_M3X7   = 64'h0000_0006_FFFF_FFEB;
`endif

  initial begin
    logic [NREQ-1:0] g;
    int exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) tick();
    @(negedge clock);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rv", 64'(resp_valid), 64'd0);
    chk("rst_p", resp_p, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    reset_n = 1'b1;

    issue_and_check("single", 0, 32'hFFFF_FFFF, 32'd2, EXP_SINGLE);

    // All four held: rotation from reset pointer.
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, rop(), rop());
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("rr_order", 64'(req_ready), 64'(oh(exp_g[c])));
      g = req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) if (g[i]) set_req(i, rop(), rop());
    end
    req_valid = '0;
    repeat (15) tick();

    // Req2 alone, then req1 and req3 join.
    set_req(2, rop(), rop());
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("solo2", 64'(req_ready), 64'b0100);
      tick();
      set_req(2, rop(), rop());
    end
    set_req(1, rop(), rop());
    set_req(3, rop(), rop());
    @(negedge clock);
    chk("join_first", 64'(req_ready), 64'b1000);
    tick();
    set_req(3, rop(), rop());
    @(negedge clock);
    chk("join_second", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    repeat (15) tick();

    // Reset with three issues in flight.
    set_req(0, rop(), rop());
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("mid_acc", 64'(req_ready), 64'b0001);
      tick();
      set_req(0, rop(), rop());
    end
    req_valid = '0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_rv", 64'(resp_valid), 64'd0);
    for (int c = 0; c < 15; c++) begin
      tick();
      @(negedge clock);
      chk("no_stale", 64'(resp_valid), 64'd0);
    end
    issue_and_check("after_rst", 3, 32'd5, 32'd6, 64'd30);

    // Response and re-grant to req1 in the same cycle.
    tick();
    set_req(1, 32'h1234, 32'h10);
    @(negedge clock);
    chk("coll_g1", 64'(req_ready), 64'b0010);
    tick();
    req_valid[1] = 1'b0;
    repeat (LAT - 1) tick();
    set_req(1, 32'd3, 32'd4);
    @(negedge clock);
    chk("coll_g2", 64'(req_ready), 64'b0010);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clock);
    chk("coll_rv1", 64'(resp_valid), 64'b0010);
    chk("coll_p1", resp_p, 64'h12340);
    repeat (LAT) @(posedge clock);
    @(negedge clock);
    chk("coll_rv2", 64'(resp_valid), 64'b0010);
    chk("coll_p2", resp_p, 64'd12);

    issue_and_check("m3x7", 2, 32'hFFFF_FFFD, 32'd7, EXP_M3X7);
    issue_and_check("minmin", 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // Random traffic with withdrawals and occasional reset.
    tick();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      g = req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (g[i] || !req_valid[i]) begin
          if ($urandom_range(0, 99) < 60) set_req(i, rop(), rop());
          else req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 5) begin
          req_valid[i] = 1'b0;
        end
      end
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
    end
    req_valid = '0;
    reset_n   = 1'b1;
    repeat (20) tick();
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
